// File: rtl/adpcm_main_sdiv_47s_15s_32_seq.sv
// ----------------------------------------------------------------------------
// adpcm_main_sdiv_47s_15s_32_seq
//
// Iterative signed divider for the ADPCM datapath. It undoes the 15s x 32s
// product: a wide 47-bit signed dividend is divided by a 15-bit signed divisor.
// The core is a radix-2 restoring divider that produces one quotient bit per
// enabled clock. The result uses C semantics: the quotient truncates toward
// zero and the remainder takes the dividend's sign.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   ce     - clock enable; while low every register holds
//   start  - request, accepted only in IDLE with ce=1
//   din0   - signed dividend, sampled on accept
//   din1   - signed divisor, sampled on accept
//   busy   - high from the accept edge until done deasserts
//   done   - result-valid pulse; it stretches while ce is low
//   quot   - signed quotient (low dout_WIDTH bits), held until next result
//   rem    - signed remainder, held until next result
//   ovf    - the quotient does not fit in dout_WIDTH signed bits
//   dbz    - the divisor was zero; quot and rem are forced to 0
// ----------------------------------------------------------------------------
module adpcm_main_sdiv_47s_15s_32_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 47,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    // The magnitudes carry one extra bit so that the most-negative operands
    // are represented exactly.
    localparam int AW = din0_WIDTH + 1;
    localparam int BW = din1_WIDTH + 1;
    localparam int PW = din1_WIDTH + 2;
    localparam int CW = $clog2(din0_WIDTH + 1);

    // The counter runs from din0_WIDTH down to 0. That gives one iteration for
    // every bit of the AW-bit magnitude, and it fixes the accept-to-done
    // latency at din0_WIDTH+2 edges.
    localparam logic [CW-1:0] ITER_LOAD = CW'(din0_WIDTH);

    localparam logic [AW-1:0] Q_MAX_NEG = AW'(1) << (dout_WIDTH - 1);
    localparam logic [AW-1:0] Q_MAX_POS = Q_MAX_NEG - AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           a_q, a_d;       // dividend bits shift out, quotient bits shift in
    logic [BW-1:0]           b_q, b_d;       // divisor magnitude
    logic [BW-1:0]           r_q, r_d;       // partial remainder
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    s0_q, s0_d;
    logic                    s1_q, s1_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [dout_WIDTH-1:0]   quot_q, quot_d;
    logic [din1_WIDTH-1:0]   rem_q, rem_d;
    logic                    ovf_q, ovf_d;
    logic                    dbz_q, dbz_d;

    logic [AW-1:0]           din0_ext, abs0;
    logic [BW-1:0]           din1_ext, abs1;
    logic [PW-1:0]           shifted, diff;
    logic                    q_neg;
    logic [dout_WIDTH-1:0]   quot_mag, quot_signed;
    logic [din1_WIDTH-1:0]   rem_mag, rem_signed;
    logic                    q_ovf;
    logic                    id_unused;

    assign id_unused = ID[0];

    always_comb begin
        din0_ext = {din0[din0_WIDTH-1], din0};
        din1_ext = {din1[din1_WIDTH-1], din1};
        abs0     = din0[din0_WIDTH-1] ? -din0_ext : din0_ext;
        abs1     = din1[din1_WIDTH-1] ? -din1_ext : din1_ext;

        // Trial subtraction. A negative result means the quotient bit is 0,
        // and the shifted remainder is kept unchanged.
        shifted  = {r_q, a_q[AW-1]};
        diff     = shifted - {1'b0, b_q};

        // Negating the low bits gives the same result as taking the low bits
        // of the negated full-width quotient.
        q_neg       = s0_q ^ s1_q;
        quot_mag    = a_q[dout_WIDTH-1:0];
        quot_signed = q_neg ? -quot_mag : quot_mag;
        rem_mag     = r_q[din1_WIDTH-1:0];
        rem_signed  = s0_q ? -rem_mag : rem_mag;
        q_ovf       = q_neg ? (a_q > Q_MAX_NEG) : (a_q > Q_MAX_POS);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        busy_d  = busy_q;
        done_d  = done_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_d     = abs0;
                        b_d     = abs1;
                        s0_d    = din0[din0_WIDTH-1];
                        s1_d    = din1[din1_WIDTH-1];
                        r_d     = '0;
                        cnt_d   = ITER_LOAD;
                        busy_d  = 1'b1;
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    if (!diff[PW-1]) begin
                        r_d = diff[BW-1:0];
                        a_d = {a_q[AW-2:0], 1'b1};
                    end else begin
                        r_d = shifted[BW-1:0];
                        a_d = {a_q[AW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (b_q == '0) begin
                        quot_d = '0;
                        rem_d  = '0;
                        ovf_d  = 1'b0;
                        dbz_d  = 1'b1;
                    end else begin
                        quot_d = quot_signed;
                        rem_d  = rem_signed;
                        ovf_d  = q_ovf;
                        dbz_d  = 1'b0;
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_adpcm_main_sdiv_47s_15s_32_seq.sv
// Testbench for adpcm_main_sdiv_47s_15s_32_seq: directed vectors with
// hand-computed results, latency, handshake, ce stall and reset abort.
module tb_adpcm_main_sdiv_47s_15s_32_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [46:0] din0;
    logic [14:0] din1;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [14:0] rem;
    logic        ovf;
    logic        dbz;

    int checks = 0;
    int passed = 0;

    adpcm_main_sdiv_47s_15s_32_seq #(
        .ID(1), .din0_WIDTH(47), .din1_WIDTH(15), .dout_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .busy(busy), .done(done),
        .quot(quot), .rem(rem), .ovf(ovf), .dbz(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Call at a negedge. Presents the operands for one accept edge and
    // returns at the negedge just after that edge.
    task automatic start_op(input logic [46:0] a, input logic [14:0] b);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen or the limit runs out, and tracks
    // whether busy stayed high the whole time.
    task automatic wait_done(input int limit, output int cycles, output bit busy_ok);
        cycles  = 0;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        checks++; if (quot !== 32'd0) $display("FAIL reset_quot: got %h want 0", quot); else passed++;
        checks++; if (rem !== 15'd0) $display("FAIL reset_rem: got %h want 0", rem); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
        checks++; if (dbz !== 1'b0) $display("FAIL reset_dbz: got %b want 0", dbz); else passed++;
    endtask

    task automatic test_basic;
        int cyc;
        bit bok;
        @(negedge clk);
        start_op(47'd100, 15'd7);
        wait_done(200, cyc, bok);
        $display("op 100/7 -> quot=%0d rem=%0d ovf=%b dbz=%b lat=%0d",
                 $signed(quot), $signed(rem), ovf, dbz, cyc);
        checks++; if (cyc != 49) $display("FAIL basic_latency: got %0d want 49", cyc); else passed++;
        checks++; if (!bok) $display("FAIL basic_busy: busy dropped before done"); else passed++;
        checks++; if (quot !== 32'd14) $display("FAIL basic_quot: got %0d want 14", $signed(quot)); else passed++;
        checks++; if (rem !== 15'd2) $display("FAIL basic_rem: got %0d want 2", $signed(rem)); else passed++;
        checks++; if (ovf !== 1'b0 || dbz !== 1'b0) $display("FAIL basic_flags: got ovf=%b dbz=%b want 0 0", ovf, dbz); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_fall: got done=%b busy=%b want 0 0", done, busy); else passed++;
    endtask

    task automatic test_signs;
        logic [46:0] va [8];
        logic [14:0] vb [8];
        logic [31:0] vq [8];
        logic [14:0] vr [8];
        logic        vo [8];
        int cyc;
        bit bok;
        va[0] = 47'(-100);           vb[0] = 15'd7;      vq[0] = 32'(-14);      vr[0] = 15'(-2); vo[0] = 1'b0;
        va[1] = 47'd100;             vb[1] = 15'(-7);    vq[1] = 32'(-14);      vr[1] = 15'd2;   vo[1] = 1'b0;
        va[2] = 47'(-100);           vb[2] = 15'(-7);    vq[2] = 32'd14;        vr[2] = 15'(-2); vo[2] = 1'b0;
        va[3] = 47'h4000_0000_0000;  vb[3] = 15'h4000;   vq[3] = 32'd0;         vr[3] = 15'd0;   vo[3] = 1'b1;
        va[4] = 47'h100_0000_0000;   vb[4] = 15'd256;    vq[4] = 32'd0;         vr[4] = 15'd0;   vo[4] = 1'b1;
        va[5] = 47'h4000_0000;       vb[5] = 15'd1;      vq[5] = 32'h4000_0000; vr[5] = 15'd0;   vo[5] = 1'b0;
        va[6] = 47'h7FFF_8000_0000;  vb[6] = 15'd1;      vq[6] = 32'h8000_0000; vr[6] = 15'd0;   vo[6] = 1'b0;
        va[7] = 47'h8000_0000;       vb[7] = 15'd1;      vq[7] = 32'h8000_0000; vr[7] = 15'd0;   vo[7] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_op(va[i], vb[i]);
            wait_done(200, cyc, bok);
            $display("op %0d: %h / %h -> quot=%h rem=%h ovf=%b dbz=%b lat=%0d",
                     i, va[i], vb[i], quot, rem, ovf, dbz, cyc);
            checks++; if (cyc != 49) $display("FAIL sign%0d_latency: got %0d want 49", i, cyc); else passed++;
            checks++; if (quot !== vq[i]) $display("FAIL sign%0d_quot: got %h want %h", i, quot, vq[i]); else passed++;
            checks++; if (rem !== vr[i]) $display("FAIL sign%0d_rem: got %h want %h", i, rem, vr[i]); else passed++;
            checks++; if (ovf !== vo[i] || dbz !== 1'b0) $display("FAIL sign%0d_flags: got ovf=%b dbz=%b want %b 0", i, ovf, dbz, vo[i]); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_dbz;
        int cyc;
        bit bok;
        @(negedge clk);
        start_op(47'd12345, 15'd0);
        wait_done(200, cyc, bok);
        $display("op 12345/0 -> quot=%h rem=%h ovf=%b dbz=%b lat=%0d", quot, rem, ovf, dbz, cyc);
        checks++; if (cyc != 49) $display("FAIL dbz_latency: got %0d want 49", cyc); else passed++;
        checks++; if (dbz !== 1'b1) $display("FAIL dbz_flag: got %b want 1", dbz); else passed++;
        checks++; if (quot !== 32'd0 || rem !== 15'd0 || ovf !== 1'b0)
            $display("FAIL dbz_forced: got quot=%h rem=%h ovf=%b want 0 0 0", quot, rem, ovf); else passed++;
        @(negedge clk);
    endtask

    task automatic test_ce_stall;
        int cyc;
        @(negedge clk);
        ce = 1'b1;
        start_op(47'd1000, 15'(-3));
        cyc = 0;
        ce  = 1'b0;
        // Only every third edge after the accept is enabled.
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            ce = ((cyc + 1) % 3 == 0);
        end
        $display("op 1000/-3 (ce 1-of-3) -> quot=%0d rem=%0d lat=%0d", $signed(quot), $signed(rem), cyc);
        checks++; if (cyc != 147) $display("FAIL stall_latency: got %0d want 147", cyc); else passed++;
        checks++; if (quot !== 32'(-333)) $display("FAIL stall_quot: got %0d want -333", $signed(quot)); else passed++;
        checks++; if (rem !== 15'd1) $display("FAIL stall_rem: got %0d want 1", $signed(rem)); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL stall_done_stretch: got %b want 1", done); else passed++;
        @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL stall_done_fall: got done=%b busy=%b want 0 0", done, busy); else passed++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit bok;
        @(negedge clk);
        start_op(47'd100, 15'd7);
        repeat (10) @(negedge clk);
        // A second request in the middle of CALC must be dropped.
        start_op(47'd500, 15'd3);
        wait_done(200, cyc, bok);
        $display("op 100/7 with mid-calc start -> quot=%0d rem=%0d lat=%0d", $signed(quot), $signed(rem), cyc + 11);
        checks++; if (cyc + 11 != 49) $display("FAIL ignore_latency: got %0d want 49", cyc + 11); else passed++;
        checks++; if (quot !== 32'd14 || rem !== 15'd2) $display("FAIL ignore_result: got %0d r %0d want 14 r 2", $signed(quot), $signed(rem)); else passed++;
        // A start during the done cycle must also be dropped.
        start_op(47'd20, 15'd3);
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL done_cycle_start: got busy=%b done=%b want 0 0", busy, done); else passed++;
        start_op(47'd20, 15'd6);
        wait_done(200, cyc, bok);
        $display("op 20/6 back-to-back -> quot=%0d rem=%0d lat=%0d", $signed(quot), $signed(rem), cyc);
        checks++; if (cyc != 49) $display("FAIL b2b_latency: got %0d want 49", cyc); else passed++;
        checks++; if (quot !== 32'd3 || rem !== 15'd2) $display("FAIL b2b_result: got %0d r %0d want 3 r 2", $signed(quot), $signed(rem)); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit bok;
        bit seen;
        @(negedge clk);
        start_op(47'd100, 15'd7);
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        $display("reset mid-op -> busy=%b done=%b quot=%h rem=%h", busy, done, quot, rem);
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", busy, done); else passed++;
        checks++; if (quot !== 32'd0 || rem !== 15'd0) $display("FAIL midrst_data: got quot=%h rem=%h want 0 0", quot, rem); else passed++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) $display("FAIL midrst_no_done: got done pulse want none"); else passed++;
        start_op(47'd100, 15'd7);
        wait_done(200, cyc, bok);
        $display("op 100/7 after reset -> quot=%0d rem=%0d lat=%0d", $signed(quot), $signed(rem), cyc);
        checks++; if (cyc != 49) $display("FAIL postrst_latency: got %0d want 49", cyc); else passed++;
        checks++; if (quot !== 32'd14 || rem !== 15'd2) $display("FAIL postrst_result: got %0d r %0d want 14 r 2", $signed(quot), $signed(rem)); else passed++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        #2;
        test_reset;
        @(negedge clk);
        reset = 1'b1;
        test_basic;
        test_signs;
        test_dbz;
        test_ce_stall;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
